// File: rtl/parallel_codebreaker_pkg.sv
// codebreaker_pkg: FSM/mode enums and the per-byte acceptance rule
// shared by parallel_codebreaker and plaintext_check.
package codebreaker_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_RUN,
    S_CHECK,
    S_FINISH
  } cb_state_t;

  typedef enum logic [1:0] {
    M_UPPER = 2'd0,
    M_PRINT = 2'd1,
    M_ALNUM = 2'd2,
    M_RSVD  = 2'd3
  } cb_mode_t;

  function automatic logic byte_ok(
    input logic [7:0] b,
    input cb_mode_t   m
  );
    logic up, lo, dg, sp, pr;
    up = (b >= 8'h41) && (b <= 8'h5A);
    lo = (b >= 8'h61) && (b <= 8'h7A);
    dg = (b >= 8'h30) && (b <= 8'h39);
    sp = (b == 8'h20);
    pr = (b >= 8'h20) && (b <= 8'h7E);
    unique case (m)
      M_PRINT: byte_ok = pr;
      M_ALNUM: byte_ok = up | lo | dg | sp;
      default: byte_ok = up | dg | sp;
    endcase
  endfunction

endpackage

// File: rtl/parallel_codebreaker_if.sv
// Search request/result bundle: start/abort/cipher/range/mode in,
// plaintext/key/done/error/busy/keys_tried out.
interface parallel_codebreaker_if #(
  parameter int KEY_W = 24
);
  logic             start;
  logic             abort;
  logic [127:0]     bytes_in;
  logic [KEY_W-1:0] key_lo;
  logic [KEY_W-1:0] key_hi;
  logic [1:0]       mode;
  logic [127:0]     bytes_out;
  logic [KEY_W-1:0] key;
  logic             done;
  logic             error;
  logic             busy;
  logic [KEY_W:0]   keys_tried;

  modport master (
    output start, abort, bytes_in,
    output key_lo, key_hi, mode,
    input  bytes_out, key, done,
    input  error, busy, keys_tried
  );

  modport slave (
    input  start, abort, bytes_in,
    input  key_lo, key_hi, mode,
    output bytes_out, key, done,
    output error, busy, keys_tried
  );
endinterface

// File: rtl/decrypt_rc4.sv
// Single RC4 lane: 3-byte key schedule then 16-byte keystream XOR.
// Ports: clk, reset (sync, high), enable, key, bytes_in -> bytes_out, done.
module decrypt_rc4 (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [23:0]  key,
  input  logic [127:0] bytes_in,
  output logic [127:0] bytes_out,
  output logic         done
);
  typedef enum logic [2:0] {
    R_IDLE,
    R_INIT,
    R_KSA,
    R_PRGA,
    R_DONE
  } rc4_state_t;

  rc4_state_t       st;
  logic [255:0][7:0] s;
  logic [7:0]       i_q, j_q;
  logic [1:0]       k_q;
  logic [3:0]       n_q;
  logic [7:0]       kb, ip, si, sj, jn, t, ks;

  function automatic logic [255:0][7:0] s_init();
    logic [255:0][7:0] r;
    for (int n = 0; n < 256; n++)
      r[n] = 8'(n);
    return r;
  endfunction

  // One swap per cycle; keystream byte is read from
  // the post-swap view of the array.
  always_comb begin
    unique case (k_q)
      2'd0:    kb = key[23:16];
      2'd1:    kb = key[15:8];
      default: kb = key[7:0];
    endcase
    ip = (st == R_PRGA) ? i_q + 8'd1 : i_q;
    si = s[ip];
    jn = j_q + si + ((st == R_KSA) ? kb : 8'd0);
    sj = s[jn];
    t  = si + sj;
    if (t == ip)
      ks = sj;
    else if (t == jn)
      ks = si;
    else
      ks = s[t];
  end

  assign done = (st == R_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= R_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      n_q       <= '0;
      bytes_out <= '0;
    end else begin
      unique case (st)
        R_IDLE: if (enable) st <= R_INIT;
        R_INIT: begin
          s   <= s_init();
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          st  <= R_KSA;
        end
        R_KSA: begin
          s[ip] <= sj;
          s[jn] <= si;
          j_q   <= jn;
          i_q   <= i_q + 8'd1;
          k_q   <= (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
          if (i_q == 8'hFF) begin
            j_q <= '0;
            n_q <= '0;
            st  <= R_PRGA;
          end
        end
        R_PRGA: begin
          s[ip] <= sj;
          s[jn] <= si;
          i_q   <= ip;
          j_q   <= jn;
          bytes_out[8*(15-int'(n_q)) +: 8] <=
            bytes_in[8*(15-int'(n_q)) +: 8] ^ ks;
          n_q <= n_q + 4'd1;
          if (n_q == 4'hF) st <= R_DONE;
        end
        R_DONE: if (!enable) st <= R_IDLE;
        default: st <= R_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/plaintext_check.sv
// Combinational acceptance test: all 16 bytes of text satisfy mode.
// Ports: text (128), mode -> pass.
module plaintext_check
  import codebreaker_pkg::*;
(
  input  logic [127:0] text,
  input  cb_mode_t     mode,
  output logic         pass
);
  always_comb begin
    pass = 1'b1;
    for (int i = 0; i < 16; i++)
      if (!byte_ok(text[8*i +: 8], mode))
        pass = 1'b0;
  end
endmodule

// File: rtl/parallel_codebreaker.sv
// NUM_LANES lock-step RC4 lanes sweeping [key_lo, key_hi].
// Ports: clk, reset_n (sync, low), cb (search request/result bundle).
module parallel_codebreaker
  import codebreaker_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int KEY_W     = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  parallel_codebreaker_if.slave cb
);
  cb_state_t            st;
  cb_mode_t             mode_q;
  logic [127:0]         ct_q;
  logic [KEY_W:0]       base_q;
  logic [KEY_W-1:0]     hi_q;
  logic [NUM_LANES-1:0] lane_en, flag, flag_n;
  logic [NUM_LANES-1:0] lane_done, lane_pass;
  logic [KEY_W:0]       lane_sum [NUM_LANES];
  logic [127:0]         lane_pt  [NUM_LANES];
  logic                 lane_rst, run, all_done;
  logic                 last_batch, found;
  logic [KEY_W:0]       n_en;
  logic [127:0]         win_pt;
  logic [KEY_W-1:0]     win_key;

  // Abort clears the lanes so the next search starts clean.
  assign lane_rst = !reset_n || cb.abort;
  assign run      = (st == S_RUN);
  assign flag_n   = flag | lane_done;
  assign all_done = &(flag_n | ~lane_en);
  assign last_batch =
    (base_q + (KEY_W+1)'(NUM_LANES)) > {1'b0, hi_q};
  assign cb.busy =
    st inside {S_LOAD, S_LAUNCH, S_RUN, S_CHECK};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_sum[g] = base_q + (KEY_W+1)'(g);

    decrypt_rc4 u_rc4 (
      .clk       (clk),
      .reset     (lane_rst),
      .enable    (lane_en[g] && run),
      .key       (24'(lane_sum[g][KEY_W-1:0])),
      .bytes_in  (ct_q),
      .bytes_out (lane_pt[g]),
      .done      (lane_done[g])
    );

    plaintext_check u_chk (
      .text (lane_pt[g]),
      .mode (mode_q),
      .pass (lane_pass[g])
    );
  end

  // Descending scan so the lowest passing lane wins.
  always_comb begin
    n_en    = '0;
    found   = 1'b0;
    win_pt  = '0;
    win_key = '0;
    for (int i = NUM_LANES-1; i >= 0; i--) begin
      n_en = n_en + (KEY_W+1)'(lane_en[i]);
      if (lane_en[i] && lane_pass[i]) begin
        found   = 1'b1;
        win_pt  = lane_pt[i];
        win_key = lane_sum[i][KEY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st            <= S_IDLE;
      mode_q        <= M_UPPER;
      ct_q          <= '0;
      base_q        <= '0;
      hi_q          <= '0;
      lane_en       <= '0;
      flag          <= '0;
      cb.bytes_out  <= '0;
      cb.key        <= '0;
      cb.done       <= 1'b0;
      cb.error      <= 1'b0;
      cb.keys_tried <= '0;
    end else begin
      cb.done  <= 1'b0;
      cb.error <= 1'b0;
      if (cb.abort && st != S_IDLE) begin
        st <= S_IDLE;
      end else begin
        unique case (st)
          S_IDLE: if (cb.start) st <= S_LOAD;
          S_LOAD: begin
            ct_q          <= cb.bytes_in;
            hi_q          <= cb.key_hi;
            mode_q        <= cb_mode_t'(cb.mode);
            base_q        <= {1'b0, cb.key_lo};
            cb.keys_tried <= '0;
            if (cb.key_lo > cb.key_hi) begin
              cb.error <= 1'b1;
              st       <= S_FINISH;
            end else begin
              st <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            for (int i = 0; i < NUM_LANES; i++)
              lane_en[i] <= lane_sum[i] <= {1'b0, hi_q};
            flag <= '0;
            st   <= S_RUN;
          end
          S_RUN: begin
            flag <= flag_n;
            if (all_done) st <= S_CHECK;
          end
          S_CHECK: begin
            cb.keys_tried <= cb.keys_tried + n_en;
            if (found) begin
              cb.bytes_out <= win_pt;
              cb.key       <= win_key;
              cb.done      <= 1'b1;
              st           <= S_FINISH;
            end else if (last_batch) begin
              cb.error <= 1'b1;
              st       <= S_FINISH;
            end else begin
              base_q <= base_q + (KEY_W+1)'(NUM_LANES);
              st     <= S_LAUNCH;
            end
          end
          S_FINISH: if (!cb.start) st <= S_IDLE;
          default:  st <= S_IDLE;
        endcase
      end
    end
  end
endmodule
